// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory request/response, the
// instruction hand-off to decode, and the PC redirect from branch/jump.
//   master : the fetch unit (drives mem_req_*, instr_valid, instruction*)
//   slave  : memory + downstream stage + redirect source
interface instruction_fetch_unit_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_address;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instruction_address;
    logic        redirect_valid;
    logic [31:0] redirect_address;

    modport master (
        output mem_req_valid,
        output mem_req_address,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data,
        output instr_valid,
        output instruction,
        output instruction_address,
        input  instr_ready,
        input  redirect_valid,
        input  redirect_address
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_address,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data,
        input  instr_valid,
        input  instruction,
        input  instruction_address,
        output instr_ready,
        output redirect_valid,
        output redirect_address
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: credit-limited memory requests, in-order
// instruction queue with fetch addresses, and redirect flush.
// Ports: clk, reset (async, active-high), bus (instruction_fetch_unit_if.master).
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input logic                      clk,
    input logic                      reset,
    instruction_fetch_unit_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW:0]   wide_t;
    typedef logic [PW-1:0] ptr_t;

    localparam ptr_t  LAST  = ptr_t'(DEPTH - 1);
    localparam wide_t LIMIT = wide_t'(DEPTH);

    logic [31:0] fetch_pc;

    logic [31:0] q_addr [DEPTH];
    logic [31:0] q_word [DEPTH];
    ptr_t        q_head;
    ptr_t        q_tail;
    cnt_t        occupancy;

    cnt_t        inflight;
    cnt_t        discard;

    logic [31:0] af_addr [DEPTH];
    ptr_t        af_head;
    ptr_t        af_tail;

    logic        req_valid;
    logic        req_fire;
    logic        resp_fire;
    logic        deq;
    logic        redirect;
    logic        resp_keep;
    logic        resp_drop;
    logic [31:0] redirect_target;

    wide_t       credit_used;
    wide_t       discard_sum;
    cnt_t        inflight_next;
    cnt_t        discard_redirect;
    cnt_t        occupancy_next;

    function automatic ptr_t bump(input ptr_t p);
        if (p == LAST) begin
            return '0;
        end
        return p + ptr_t'(1);
    endfunction

    // Credit counts both buffered words and outstanding requests, so a
    // returning word always has a free queue slot.
    assign credit_used = wide_t'(occupancy) + wide_t'(inflight);
    assign req_valid   = credit_used < LIMIT;

    assign req_fire  = req_valid & bus.mem_req_ready;
    assign resp_fire = bus.mem_resp_valid;
    assign deq       = (occupancy != '0) & bus.instr_ready;
    assign redirect  = bus.redirect_valid;

    assign redirect_target = bus.redirect_address & 32'hFFFF_FFFC;

    // Stale responses are dropped while discard is nonzero.
    assign resp_drop = resp_fire & (discard != '0);
    assign resp_keep = resp_fire & ~redirect & (discard == '0);

    always_comb begin
        inflight_next = inflight
                      + cnt_t'(req_fire)
                      - cnt_t'(resp_fire);
        discard_sum   = wide_t'(discard)
                      + wide_t'(inflight)
                      + wide_t'(req_fire)
                      - wide_t'(resp_fire);
        // Everything still outstanding after a redirect is stale;
        // discard can never exceed what is actually in flight.
        if (discard_sum > wide_t'(inflight_next)) begin
            discard_redirect = inflight_next;
        end else begin
            discard_redirect = discard_sum[CW-1:0];
        end
        occupancy_next = occupancy
                       + cnt_t'(resp_keep)
                       - cnt_t'(deq);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            q_head    <= '0;
            q_tail    <= '0;
            occupancy <= '0;
            inflight  <= '0;
            discard   <= '0;
            af_head   <= '0;
            af_tail   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_addr[i]  <= '0;
                q_word[i]  <= '0;
                af_addr[i] <= '0;
            end
        end else begin
            inflight <= inflight_next;

            // The address FIFO tracks every outstanding request, stale
            // or not, so its pop stays aligned with memory responses.
            if (req_fire) begin
                af_addr[af_tail] <= fetch_pc;
                af_tail          <= bump(af_tail);
            end
            if (resp_fire) begin
                af_head <= bump(af_head);
            end

            if (redirect) begin
                fetch_pc  <= redirect_target;
                q_head    <= '0;
                q_tail    <= '0;
                occupancy <= '0;
                discard   <= discard_redirect;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (resp_drop) begin
                    discard <= discard - cnt_t'(1);
                end
                if (resp_keep) begin
                    q_addr[q_tail] <= af_addr[af_head];
                    q_word[q_tail] <= bus.mem_resp_data;
                    q_tail         <= bump(q_tail);
                end
                if (deq) begin
                    q_head <= bump(q_head);
                end
                occupancy <= occupancy_next;
            end
        end
    end

    assign bus.mem_req_valid       = req_valid;
    assign bus.mem_req_address     = fetch_pc;
    assign bus.instr_valid         = occupancy != '0;
    assign bus.instruction         = q_word[q_head];
    assign bus.instruction_address = q_addr[q_head];

endmodule
